// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - 8-channel interrupt request conditioner with bus-readable pending/enable/mode/polarity
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer on every dev_irq line.
module irq_ctrl #(
    parameter int CH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] dev_irq,
    input  logic          cs_,
    input  logic          as_,
    input  logic          rw,
    input  logic [1:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic          rdy_,
    output logic [CH-1:0] irq
);

    logic [CH-1:0] pending, enable, mode, polarity, prev;
    logic [CH-1:0] samp, s, set_edge, clr, pending_n, prev_n;
    logic [CH-1:0] wdata;
    logic [31:0]   rd_val;
    logic          access, wr_pend, wr_en, wr_mode, wr_pol;
    logic          unused_hi;

`ifdef IRQ_SYNC_EN
    logic [CH-1:0] sync1, sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= dev_irq;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = dev_irq;
`endif

    assign access    = ~cs_ & ~as_;
    assign wr_pend   = access & ~rw & (addr == 2'd0);
    assign wr_en     = access & ~rw & (addr == 2'd1);
    assign wr_mode   = access & ~rw & (addr == 2'd2);
    assign wr_pol    = access & ~rw & (addr == 2'd3);
    assign wdata     = wr_data[CH-1:0];
    assign unused_hi = ^wr_data[31:CH];

    always_comb begin
        s         = samp ^ polarity;
        set_edge  = s & ~prev;
        clr       = wr_pend ? wdata : '0;
        // Edge channels: a fresh edge beats a simultaneous W1C. Level channels track s.
        pending_n = (mode & (set_edge | (pending & ~clr))) | (~mode & s);
        if (wr_mode) begin
            pending_n = pending_n & ~(mode ^ wdata);
        end
        // Reloading prev with the new-polarity sample keeps a polarity flip from looking like an edge.
        prev_n    = wr_pol ? (samp ^ wdata) : s;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            2'd0:    rd_val[CH-1:0] = pending;
            2'd1:    rd_val[CH-1:0] = enable;
            2'd2:    rd_val[CH-1:0] = mode;
            default: rd_val[CH-1:0] = polarity;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            enable   <= '0;
            mode     <= '0;
            polarity <= '0;
            prev     <= '0;
            irq      <= '0;
            rd_data  <= '0;
            rdy_     <= 1'b1;
        end else begin
            pending  <= pending_n;
            prev     <= prev_n;
            irq      <= pending & enable;
            if (wr_en)   enable   <= wdata;
            if (wr_mode) mode     <= wdata;
            if (wr_pol)  polarity <= wdata;
            rdy_     <= ~access;
            rd_data  <= (access & rw) ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl: queued bus responses plus directed irq checks
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  dev_irq = '0;
    logic        cs_ = 1'b1;
    logic        as_ = 1'b1;
    logic        rw = 1'b1;
    logic [1:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        rdy_;
    logic [7:0]  irq;

    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_q[$];

    irq_ctrl #(.CH(8)) dut (
        .clk(clk), .reset(reset), .dev_irq(dev_irq), .cs_(cs_), .as_(as_),
        .rw(rw), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .rdy_(rdy_), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic r, input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
        exp_q.push_back(exp);
        tick();
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = '0;
    endtask

    // Monitor: every completed access must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && !rdy_) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL bus_resp: got unexpected rdy_ with rd_data 0x%0h expected no response", rd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rd_data === e) passed++;
                else $display("FAIL bus_rd_data: got 0x%0h expected 0x%0h", rd_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        check("reset_rdy", {31'd0, rdy_}, 32'd1);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_irq", {24'd0, irq}, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) acc(1'b1, 2'(i), 32'd0, 32'd0);
        check("post_reset_irq", {24'd0, irq}, 32'd0);

        // Edge channel 0 pulse, then W1C
        acc(1'b0, 2'd2, 32'h01, 32'd0);
        acc(1'b0, 2'd1, 32'h01, 32'd0);
        dev_irq[0] = 1'b1;
        tick();
        dev_irq[0] = 1'b0;
        repeat (SYNC) tick();
        check("edge_irq_lat_lo", {24'd0, irq}, 32'h00);
        tick();
        check("edge_irq_hi", {24'd0, irq}, 32'h01);
        tick();
        check("edge_irq_held", {24'd0, irq}, 32'h01);
        acc(1'b1, 2'd0, 32'd0, 32'h01);
        acc(1'b0, 2'd0, 32'h01, 32'd0);
        check("w1c_irq_lag", {24'd0, irq}, 32'h01);
        tick();
        check("w1c_irq_clr", {24'd0, irq}, 32'h00);
        acc(1'b1, 2'd0, 32'd0, 32'h00);

        // Level channel 3
        acc(1'b0, 2'd2, 32'h00, 32'd0);
        acc(1'b0, 2'd1, 32'h08, 32'd0);
        dev_irq[3] = 1'b1;
        tick();
        repeat (SYNC) tick();
        check("level_irq_lat_lo", {24'd0, irq}, 32'h00);
        tick();
        check("level_irq_hi", {24'd0, irq}, 32'h08);
        acc(1'b0, 2'd0, 32'h08, 32'd0);
        tick();
        check("level_w1c_ignored", {24'd0, irq}, 32'h08);
        acc(1'b1, 2'd0, 32'd0, 32'h08);
        dev_irq[3] = 1'b0;
        tick();
        repeat (SYNC) tick();
        check("level_fall_lag", {24'd0, irq}, 32'h08);
        tick();
        check("level_irq_lo", {24'd0, irq}, 32'h00);

        // Falling-edge channel 2
        acc(1'b0, 2'd3, 32'h04, 32'd0);
        acc(1'b0, 2'd2, 32'h04, 32'd0);
        acc(1'b0, 2'd1, 32'h04, 32'd0);
        acc(1'b1, 2'd0, 32'd0, 32'h00);
        acc(1'b1, 2'd3, 32'd0, 32'h04);
        dev_irq[2] = 1'b1;
        tick();
        repeat (SYNC) tick();
        acc(1'b1, 2'd0, 32'd0, 32'h00);
        dev_irq[2] = 1'b0;
        tick();
        repeat (SYNC) tick();
        tick();
        check("fall_irq", {24'd0, irq}, 32'h04);
        acc(1'b1, 2'd0, 32'd0, 32'h04);
        acc(1'b0, 2'd0, 32'h04, 32'd0);
        acc(1'b0, 2'd3, 32'h00, 32'd0);

        // Set beats simultaneous W1C on channel 0
        acc(1'b0, 2'd2, 32'h01, 32'd0);
        acc(1'b0, 2'd1, 32'h01, 32'd0);
        dev_irq[0] = 1'b1;
        tick();
        dev_irq[0] = 1'b0;
        repeat (SYNC) tick();
        repeat (2) tick();
        check("collide_pre_irq", {24'd0, irq}, 32'h01);
        dev_irq[0] = 1'b1;
        repeat (SYNC) tick();
        acc(1'b0, 2'd0, 32'h01, 32'd0);
        check("collide_irq_0", {24'd0, irq}, 32'h01);
        tick();
        check("collide_irq_1", {24'd0, irq}, 32'h01);
        acc(1'b1, 2'd0, 32'd0, 32'h01);
        dev_irq[0] = 1'b0;

        // Enable masking with pending latched
        acc(1'b0, 2'd1, 32'h00, 32'd0);
        tick();
        check("masked_irq", {24'd0, irq}, 32'h00);
        acc(1'b1, 2'd0, 32'd0, 32'h01);
        acc(1'b0, 2'd1, 32'h01, 32'd0);
        check("unmask_lag", {24'd0, irq}, 32'h00);
        tick();
        check("unmask_irq", {24'd0, irq}, 32'h01);

        // Reset in the middle of a read
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd1;
        tick();
        check("midread_rdy", {31'd0, rdy_}, 32'd0);
        check("midread_data", rd_data, 32'h01);
        reset = 1'b0;
        #1;
        check("abort_rdy", {31'd0, rdy_}, 32'd1);
        check("abort_rd_data", rd_data, 32'd0);
        check("abort_irq", {24'd0, irq}, 32'h00);
        cs_ = 1'b1; as_ = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        acc(1'b1, 2'd0, 32'd0, 32'h00);
        acc(1'b1, 2'd1, 32'd0, 32'h00);
        acc(1'b1, 2'd2, 32'd0, 32'h00);
        acc(1'b1, 2'd3, 32'd0, 32'h00);
        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Peripheral-side interrupt request controller that generates the 8-channel `irq` vector consumed by the CPU control unit's interrupt detection. It collects raw device interrupt lines and conditions each one per channel: edge or level mode, selectable polarity, latched pending bit and enable mask. Software reads and clears the controller through a single-cycle-latency bus slave port. It sits on the peripheral bus, between the devices and the CPU `irq` input.

## Interface
- `CH`, 8: number of interrupt channels; must equal the CPU IRQ channel count.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `dev_irq` input CH: raw device interrupt lines, possibly asynchronous to `clk`.
- `cs_` input 1: chip select, active-low.
- `as_` input 1: address strobe, active-low; an access occurs when `cs_`=0 and `as_`=0.
- `rw` input 1: 1 = read, 0 = write.
- `addr` input 2: register index.
- `wr_data` input 32: write data.
- `rd_data` output 32: read data, registered.
- `rdy_` output 1: access complete, active-low, registered.
- `irq` output CH: conditioned requests to the CPU, registered; equals `pending & enable`.

## Operation
- Register map, by `addr`:
  - 0 PENDING: read returns pending[CH-1:0]. Write is write-1-to-clear on edge channels only.
  - 1 ENABLE: read/write mask; 1 = forwarded to `irq`.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 POLARITY: read/write; 0 = active-high/rising, 1 = active-low/falling.
- Bits 31:CH read as 0 and are ignored on write.
- Per channel, `s` is the sampled input XOR POLARITY[i]. `p` is `s` registered one cycle (the previous sample).
- Edge channel:
  - pending[i] is set when `s`=1 and `p`=0.
  - It stays set until cleared by a W1C write.
  - If a set and a clear occur in the same cycle, the set wins.
- Level channel: pending[i] <= `s` every cycle. Writes to PENDING do not affect it.
- A write to MODE clears pending[i] on every channel whose mode bit changes.
- A write to POLARITY also reloads `p` with the new `s`, so a polarity change alone never creates an edge.
- Register writes take effect at the edge ending the access cycle.
- `irq` <= pending & enable every cycle, including the cycle in which ENABLE is written (the new mask is used from the next edge).
- Bus slave behaviour:
  - On an access at edge k, `rdy_`=0 for exactly one cycle after edge k.
  - For a read, `rd_data` holds the register value from before edge k.
  - Otherwise `rd_data`=0 and `rdy_`=1.
  - Back-to-back accesses are allowed, one per cycle.
- Reset values:
  - `rd_data`=0, `rdy_`=1, `irq`=0.
  - pending, enable, mode and polarity all 0.
  - Synchronizer and `p` registers all 0.

## Timing
- Without IRQ_SYNC_EN:
  - A rising `dev_irq` sampled at edge k sets pending at edge k.
  - `irq` is high after edge k+1.
- With IRQ_SYNC_EN:
  - pending is set at edge k+2.
  - `irq` is high after edge k+3.
- W1C write at edge k: pending is 0 after edge k and `irq` is 0 after edge k+1, unless a new edge also arrives at edge k.
- Read latency: 1 cycle. Write latency: 1 cycle.
- Asserting `reset` mid-access aborts the access:
  - `rdy_` returns to 1 immediately.
  - All registers return to their reset values.

## Configuration
- `IRQ_SYNC_EN` defined: each `dev_irq` bit passes through a 2-flop synchronizer before polarity and edge logic; latency is +2 cycles.
- Not defined: `dev_irq` is used directly. Inputs must then be synchronous to `clk`.

## Test plan
- Reset, then read addr 0..3 -> each returns 0 with `rdy_`=0 one cycle after the access; `irq`=0.
- Write MODE=0x01, ENABLE=0x01, then pulse `dev_irq`[0] high for 1 cycle -> `irq`=0x01 at the stated latency and held; W1C 0x01 to PENDING -> `irq`=0x00 one cycle later.
- Level channel 3 (MODE=0, ENABLE=0x08), drive `dev_irq`[3] high then low -> `irq`[3] follows with the stated latency; a W1C write of 0x08 has no effect while the input stays high.
- POLARITY=0x04, MODE=0x04, ENABLE=0x04, falling edge on `dev_irq`[2] -> PENDING reads 0x04; rising edge alone -> no set.
- Edge channel 0: a new rising edge arrives in the same cycle as the W1C write -> pending stays 1 and `irq`[0] stays high.
- ENABLE=0 with a pending edge latched -> `irq`=0 while PENDING reads 1; then ENABLE=0x01 -> `irq`=0x01 one cycle later. Assert `reset` mid-read -> `rdy_`=1 and all registers return to 0.
